// File: rtl/secuenciador_comandos_teclado.sv
// secuenciador_comandos_teclado: PS/2 scan-code parser producing one-cycle UI commands.
// Optional macro TYPEMATIC_FILTER_EN drops typematic repeats of the held key.
`default_nettype none

module secuenciador_comandos_teclado #(
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int CNT_W          = 20,
  parameter logic [7:0] ALARM_KEY = 8'h79
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] tecla,
  input  logic       got_data,
  input  logic       alarma_activa,
  output logic       cmd_valid,
  output logic [2:0] cmd_code,
  output logic [3:0] digito,
  output logic       salida_reset_alarma,
  output logic       error_teclado
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] EXT     = 2'd1;
  localparam logic [1:0] BRK     = 2'd2;
  localparam logic [1:0] EXT_BRK = 2'd3;

  localparam logic [2:0] CMD_DIGIT = 3'd0;
  localparam logic [2:0] CMD_ENTER = 3'd1;
  localparam logic [2:0] CMD_CLEAR = 3'd2;
  localparam logic [2:0] CMD_UP    = 3'd3;
  localparam logic [2:0] CMD_DOWN  = 3'd4;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             valid_nxt, alarm_nxt, err_nxt;
  logic [2:0]       code_nxt;
  logic [3:0]       dig_nxt;

  // Raw decode of the current byte, before repeat filtering and state gating
  logic       plain_hit, ext_hit, is_alarm;
  logic [2:0] plain_code, ext_code;
  logic [3:0] plain_dig;

  always_comb begin
    plain_hit  = 1'b1;
    plain_code = CMD_DIGIT;
    plain_dig  = 4'd0;
    case (tecla)
      8'h70: plain_dig = 4'd0;
      8'h69: plain_dig = 4'd1;
      8'h72: plain_dig = 4'd2;
      8'h7A: plain_dig = 4'd3;
      8'h6B: plain_dig = 4'd4;
      8'h73: plain_dig = 4'd5;
      8'h74: plain_dig = 4'd6;
      8'h6C: plain_dig = 4'd7;
      8'h75: plain_dig = 4'd8;
      8'h7D: plain_dig = 4'd9;
      8'h5A: plain_code = CMD_ENTER;
      8'h66: plain_code = CMD_CLEAR;
      default: plain_hit = 1'b0;
    endcase
    is_alarm = (tecla == ALARM_KEY);

    ext_hit  = 1'b1;
    ext_code = CMD_UP;
    case (tecla)
      8'h75: ext_code = CMD_UP;
      8'h72: ext_code = CMD_DOWN;
      default: ext_hit = 1'b0;
    endcase
  end

`ifdef TYPEMATIC_FILTER_EN
  logic [7:0] held, held_nxt;
  logic       repeat_key;
  assign repeat_key = (tecla == held);
`else
  logic       repeat_key;
  assign repeat_key = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    valid_nxt = 1'b0;
    code_nxt  = 3'd0;
    dig_nxt   = 4'd0;
    alarm_nxt = 1'b0;
    err_nxt   = 1'b0;
`ifdef TYPEMATIC_FILTER_EN
    held_nxt  = held;
`endif
    if (got_data) begin
      // A byte always wins over a timeout expiring in the same cycle
      cnt_nxt = '0;
      case (state)
        IDLE: begin
          if (tecla == 8'hE0) begin
            state_nxt = EXT;
          end else if (tecla == 8'hF0) begin
            state_nxt = BRK;
          end else if (plain_hit && !repeat_key) begin
            valid_nxt = 1'b1;
            code_nxt  = plain_code;
            dig_nxt   = plain_dig;
`ifdef TYPEMATIC_FILTER_EN
            held_nxt  = tecla;
`endif
          end else if (is_alarm && !repeat_key) begin
            alarm_nxt = alarma_activa;
`ifdef TYPEMATIC_FILTER_EN
            held_nxt  = tecla;
`endif
          end
        end
        EXT: begin
          if (tecla == 8'hF0) begin
            state_nxt = EXT_BRK;
          end else if (tecla != 8'hE0) begin
            state_nxt = IDLE;
            if (ext_hit) begin
              if (!repeat_key) begin
                valid_nxt = 1'b1;
                code_nxt  = ext_code;
`ifdef TYPEMATIC_FILTER_EN
                held_nxt  = tecla;
`endif
              end
            end else begin
              err_nxt = 1'b1;
            end
          end
        end
        default: begin
          state_nxt = IDLE;
`ifdef TYPEMATIC_FILTER_EN
          if (repeat_key) held_nxt = 8'h00;
`endif
        end
      endcase
    end else if (state != IDLE) begin
      if (cnt == CNT_LAST) begin
        state_nxt = IDLE;
        err_nxt   = 1'b1;
        cnt_nxt   = '0;
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state               <= IDLE;
      cnt                 <= '0;
      cmd_valid           <= 1'b0;
      cmd_code            <= 3'd0;
      digito              <= 4'd0;
      salida_reset_alarma <= 1'b0;
      error_teclado       <= 1'b0;
    end else begin
      state               <= state_nxt;
      cnt                 <= cnt_nxt;
      cmd_valid           <= valid_nxt;
      cmd_code            <= code_nxt;
      digito              <= dig_nxt;
      salida_reset_alarma <= alarm_nxt;
      error_teclado       <= err_nxt;
    end
  end

`ifdef TYPEMATIC_FILTER_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) held <= 8'h00;
    else          held <= held_nxt;
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_secuenciador_comandos_teclado.sv
// Scoreboard bench for secuenciador_comandos_teclado: expected output vectors queued per driven cycle.
`default_nettype none

module tb_secuenciador_comandos_teclado;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] tecla = 8'h00;
  logic       got_data = 1'b0;
  logic       alarma_activa = 1'b0;
  logic       cmd_valid;
  logic [2:0] cmd_code;
  logic [3:0] digito;
  logic       salida_reset_alarma;
  logic       error_teclado;

  int vectors = 0;
  int miscompares = 0;
  logic [9:0] sb_q[$];

  always #5 clk = ~clk;

  secuenciador_comandos_teclado #(
    .TIMEOUT_CYCLES(16),
    .CNT_W(5),
    .ALARM_KEY(8'h79)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .tecla(tecla),
    .got_data(got_data),
    .alarma_activa(alarma_activa),
    .cmd_valid(cmd_valid),
    .cmd_code(cmd_code),
    .digito(digito),
    .salida_reset_alarma(salida_reset_alarma),
    .error_teclado(error_teclado)
  );

  // Vector layout: {cmd_valid, cmd_code, digito, salida_reset_alarma, error_teclado}
  localparam logic [9:0] NONE = 10'b0;
  localparam logic [9:0] ENTER = {1'b1, 3'd1, 4'd0, 2'b00};
  localparam logic [9:0] UP    = {1'b1, 3'd3, 4'd0, 2'b00};
  localparam logic [9:0] DOWN  = {1'b1, 3'd4, 4'd0, 2'b00};
  localparam logic [9:0] ALRM  = 10'b00000000_10;
  localparam logic [9:0] ERR   = 10'b00000000_01;

  function automatic logic [9:0] dig(input int d);
    return {1'b1, 3'd0, 4'(d), 2'b00};
  endfunction

  task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  // One clock: drive, queue the expectation, then pop it against the registered outputs
  task automatic step(input string tag, input logic gd, input logic [7:0] b, input logic [9:0] exp);
    logic [9:0] e;
    @(negedge clk);
    got_data = gd;
    tecla    = b;
    sb_q.push_back(exp);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check(tag, {cmd_valid, cmd_code, digito, salida_reset_alarma, error_teclado}, e);
    got_data = 1'b0;
  endtask

  task automatic byte_in(input string tag, input logic [7:0] b, input logic [9:0] exp);
    step(tag, 1'b1, b, exp);
  endtask

  initial begin
    logic [7:0] keys [10];
    keys = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D};

    repeat (2) @(posedge clk);
    #1;
    check("reset", {cmd_valid, cmd_code, digito, salida_reset_alarma, error_teclado}, NONE);
    @(negedge clk);
    reset_n = 1'b1;

    byte_in("d0", 8'h70, dig(0));
    byte_in("brk_f0", 8'hF0, NONE);
    byte_in("brk_70", 8'h70, NONE);

    for (int i = 0; i < 10; i++) begin
      byte_in($sformatf("digit%0d", i), keys[i], dig(i));
      byte_in("f0", 8'hF0, NONE);
      byte_in("brk", keys[i], NONE);
    end

    byte_in("enter", 8'h5A, ENTER);
    byte_in("clear", 8'h66, {1'b1, 3'd2, 4'd0, 2'b00});
    byte_in("unmapped_plain", 8'h1C, NONE);
    step("idle", 1'b0, 8'h00, NONE);

    byte_in("e0", 8'hE0, NONE);
    byte_in("up", 8'h75, UP);
    byte_in("e0", 8'hE0, NONE);
    byte_in("down", 8'h72, DOWN);
    byte_in("e0", 8'hE0, NONE);
    byte_in("e0f0", 8'hF0, NONE);
    byte_in("extbrk", 8'h75, NONE);
    byte_in("e0", 8'hE0, NONE);
    byte_in("ext_unmapped", 8'h7A, ERR);
    byte_in("after_err_idle", 8'h5A, ENTER);
    byte_in("e0", 8'hE0, NONE);
    byte_in("e0e0", 8'hE0, NONE);
    byte_in("e0e0_up", 8'h75, UP);

    alarma_activa = 1'b1;
    byte_in("alarm_on", 8'h79, ALRM);
    byte_in("f0", 8'hF0, NONE);
    byte_in("alarm_brk", 8'h79, NONE);
    alarma_activa = 1'b0;
    byte_in("alarm_off", 8'h79, NONE);
    byte_in("f0", 8'hF0, NONE);
    byte_in("alarm_brk", 8'h79, NONE);

    // Timeout: F0 then silence; expiry lands on the 16th idle cycle
    byte_in("to_f0", 8'hF0, NONE);
    for (int i = 1; i < 16; i++) step($sformatf("to_wait%0d", i), 1'b0, 8'h00, NONE);
    step("to_expire", 1'b0, 8'h00, ERR);
    byte_in("to_enter", 8'h5A, ENTER);

    // Byte arriving exactly at expiry is processed, no error
    byte_in("race_e0", 8'hE0, NONE);
    for (int i = 1; i < 16; i++) step($sformatf("race_wait%0d", i), 1'b0, 8'h00, NONE);
    byte_in("race_up", 8'h75, UP);

`ifdef TYPEMATIC_FILTER_EN
    byte_in("tm1", 8'h69, dig(1));
    byte_in("tm2", 8'h69, NONE);
    byte_in("tm3", 8'h69, NONE);
    byte_in("tm_f0", 8'hF0, NONE);
    byte_in("tm_brk", 8'h69, NONE);
    byte_in("tm4", 8'h69, dig(1));
`else
    byte_in("rep1", 8'h69, dig(1));
    byte_in("rep2", 8'h69, dig(1));
`endif

    // Reset mid-sequence discards the E0 prefix
    byte_in("rst_e0", 8'hE0, NONE);
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check("in_reset", {cmd_valid, cmd_code, digito, salida_reset_alarma, error_teclado}, NONE);
    @(negedge clk);
    reset_n = 1'b1;
    step("post_rst_idle", 1'b0, 8'h00, NONE);
    byte_in("post_rst_75", 8'h75, dig(8));

    step("tail", 1'b0, 8'h00, NONE);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
